// File: rtl/sif_bridge_if.sv
// Groups the external access port (xa_*) and the downstream write-access port (wa_*).
interface sif_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              xa_wr_s;
  logic              xa_rd_s;
  logic [ADDR_W-1:0] xa_addr;
  logic [DATA_W-1:0] xa_data_wr;
  logic [DATA_W-1:0] xa_data_rd;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data_wr;
  logic              wa_wr_s;

  modport master (
    output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr,
    input  xa_data_rd, wa_addr, wa_data_wr, wa_wr_s
  );

  modport slave (
    input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr,
    output xa_data_rd, wa_addr, wa_data_wr, wa_wr_s
  );
endinterface

// File: rtl/sif_bridge.sv
// Shadow register bank for an external master; accepted writes are forwarded one cycle
// later to the downstream register file as a single-cycle strobe.
module sif_bridge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  sif_bridge_if.slave  bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic [ADDR_W-1:0] waAddr_q, waAddr_d;
  logic [DATA_W-1:0] waData_q, waData_d;
  logic              waWr_q,   waWr_d;

  logic              addrInRange;
  logic              wrAccept;
  logic [IDX_W-1:0]  idx;

  // Upper address bits only take part in the range check, never in indexing.
  assign addrInRange = ({1'b0, bus.xa_addr} < DEPTH_LIM);
  assign idx         = bus.xa_addr[IDX_W-1:0];
  assign wrAccept    = bus.xa_wr_s & addrInRange;

  always_comb begin
    rdData_d = rdData_q;
    waAddr_d = waAddr_q;
    waData_d = waData_q;
    waWr_d   = 1'b0;
    if (bus.xa_rd_s) begin
      rdData_d = addrInRange ? shadow_q[idx] : '0;
    end
    if (wrAccept) begin
      waAddr_d = bus.xa_addr;
      waData_d = bus.xa_data_wr;
      waWr_d   = 1'b1;
    end
  end

  // The read above samples shadow_q before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
      rdData_q <= '0;
      waAddr_q <= '0;
      waData_q <= '0;
      waWr_q   <= 1'b0;
    end else begin
      if (wrAccept) begin
        shadow_q[idx] <= bus.xa_data_wr;
      end
      rdData_q <= rdData_d;
      waAddr_q <= waAddr_d;
      waData_q <= waData_d;
      waWr_q   <= waWr_d;
    end
  end

  assign bus.xa_data_rd = rdData_q;
  assign bus.wa_addr    = waAddr_q;
  assign bus.wa_data_wr = waData_q;
  assign bus.wa_wr_s    = waWr_q;

endmodule

// File: tb/tb_sif_bridge.sv
// Directed vector bench for sif_bridge: a table of per-cycle stimulus with hand-computed
// expected outputs, followed by a fill/readback sequence over the whole shadow bank.
module tb_sif_bridge;

  typedef struct {
    logic        rstB;
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] expRd;
    logic        expWaWr;
    logic [7:0]  expWaAddr;
    logic [15:0] expWaData;
  } vec_t;

  logic clk = 1'b0;
  logic rstB;
  vec_t vecs[$];
  logic [15:0] model [16];
  int checks   = 0;
  int failures = 0;

  sif_bridge_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  sif_bridge #(.ADDR_W(8), .DATA_W(16), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_b (rstB),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic rb, input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [15:0] data, input logic [15:0] expRd, input logic expWaWr,
                        input logic [7:0] expWaAddr, input logic [15:0] expWaData);
    vec_t v;
    v = '{rb, wr, rd, addr, data, expRd, expWaWr, expWaAddr, expWaData};
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs, then waits until just after the sampling edge.
  task automatic applyStimulus(input logic rb, input logic wr, input logic rd,
                               input logic [7:0] addr, input logic [15:0] data);
    rstB           = rb;
    bus.xa_wr_s    = wr;
    bus.xa_rd_s    = rd;
    bus.xa_addr    = addr;
    bus.xa_data_wr = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    rstB           = 1'b0;
    bus.xa_wr_s    = 1'b0;
    bus.xa_rd_s    = 1'b0;
    bus.xa_addr    = '0;
    bus.xa_data_wr = '0;

    //      rstB  wr    rd    addr   data      expRd     waWr  waAddr waData
    addVec(1'b0, 1'b1, 1'b0, 8'd2,  16'h2222, 16'h0000, 1'b0, 8'd0,  16'h0000);
    addVec(1'b0, 1'b0, 1'b0, 8'd0,  16'h0000, 16'h0000, 1'b0, 8'd0,  16'h0000);
    addVec(1'b1, 1'b0, 1'b1, 8'd2,  16'h0000, 16'h0000, 1'b0, 8'd0,  16'h0000);
    addVec(1'b1, 1'b1, 1'b0, 8'd3,  16'hA5A5, 16'h0000, 1'b1, 8'd3,  16'hA5A5);
    addVec(1'b1, 1'b0, 1'b0, 8'd0,  16'h0000, 16'h0000, 1'b0, 8'd3,  16'hA5A5);
    addVec(1'b1, 1'b0, 1'b1, 8'd3,  16'h0000, 16'hA5A5, 1'b0, 8'd3,  16'hA5A5);
    addVec(1'b1, 1'b1, 1'b0, 8'd0,  16'h1111, 16'hA5A5, 1'b1, 8'd0,  16'h1111);
    addVec(1'b1, 1'b1, 1'b0, 8'd15, 16'hFFFF, 16'hA5A5, 1'b1, 8'd15, 16'hFFFF);
    addVec(1'b1, 1'b0, 1'b0, 8'd0,  16'h0000, 16'hA5A5, 1'b0, 8'd15, 16'hFFFF);
    addVec(1'b1, 1'b0, 1'b1, 8'd0,  16'h0000, 16'h1111, 1'b0, 8'd15, 16'hFFFF);
    addVec(1'b1, 1'b0, 1'b1, 8'd15, 16'h0000, 16'hFFFF, 1'b0, 8'd15, 16'hFFFF);
    addVec(1'b1, 1'b1, 1'b0, 8'd16, 16'hDEAD, 16'hFFFF, 1'b0, 8'd15, 16'hFFFF);
    addVec(1'b1, 1'b0, 1'b1, 8'd16, 16'h0000, 16'h0000, 1'b0, 8'd15, 16'hFFFF);
    addVec(1'b1, 1'b1, 1'b0, 8'd5,  16'h0005, 16'h0000, 1'b1, 8'd5,  16'h0005);
    addVec(1'b1, 1'b1, 1'b1, 8'd5,  16'h5555, 16'h0005, 1'b1, 8'd5,  16'h5555);
    addVec(1'b1, 1'b0, 1'b1, 8'd5,  16'h0000, 16'h5555, 1'b0, 8'd5,  16'h5555);
    addVec(1'b1, 1'b1, 1'b0, 8'd7,  16'h7777, 16'h5555, 1'b1, 8'd7,  16'h7777);
    addVec(1'b1, 1'b0, 1'b1, 8'd7,  16'h0000, 16'h7777, 1'b0, 8'd7,  16'h7777);
    addVec(1'b1, 1'b1, 1'b0, 8'd200, 16'hBEEF, 16'h7777, 1'b0, 8'd7, 16'h7777);
    addVec(1'b1, 1'b0, 1'b1, 8'd8,  16'h0000, 16'h0000, 1'b0, 8'd7,  16'h7777);
    addVec(1'b1, 1'b0, 1'b1, 8'h13, 16'h0000, 16'h0000, 1'b0, 8'd7,  16'h7777);
    addVec(1'b0, 1'b1, 1'b0, 8'd2,  16'h2222, 16'h0000, 1'b0, 8'd0,  16'h0000);
    addVec(1'b1, 1'b0, 1'b0, 8'd0,  16'h0000, 16'h0000, 1'b0, 8'd0,  16'h0000);
    addVec(1'b1, 1'b0, 1'b1, 8'd2,  16'h0000, 16'h0000, 1'b0, 8'd0,  16'h0000);
    addVec(1'b1, 1'b0, 1'b1, 8'd3,  16'h0000, 16'h0000, 1'b0, 8'd0,  16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstB, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d.xa_data_rd", i), 32'(bus.xa_data_rd), 32'(vecs[i].expRd));
      checkOutput($sformatf("vec%0d.wa_wr_s", i),    32'(bus.wa_wr_s),    32'(vecs[i].expWaWr));
      checkOutput($sformatf("vec%0d.wa_addr", i),    32'(bus.wa_addr),    32'(vecs[i].expWaAddr));
      checkOutput($sformatf("vec%0d.wa_data_wr", i), 32'(bus.wa_data_wr), 32'(vecs[i].expWaData));
    end

    // Fill the whole bank back-to-back, then an out-of-range write must disturb nothing.
    for (int i = 0; i < 16; i++) begin
      model[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(i), model[i]);
      checkOutput($sformatf("fill%0d.wa_wr_s", i),    32'(bus.wa_wr_s),    32'd1);
      checkOutput($sformatf("fill%0d.wa_addr", i),    32'(bus.wa_addr),    32'(i));
      checkOutput($sformatf("fill%0d.wa_data_wr", i), 32'(bus.wa_data_wr), 32'(model[i]));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd16, 16'hDEAD);
    checkOutput("oor.wa_wr_s",    32'(bus.wa_wr_s),    32'd0);
    checkOutput("oor.wa_addr",    32'(bus.wa_addr),    32'd15);
    checkOutput("oor.wa_data_wr", 32'(bus.wa_data_wr), 32'(model[15]));
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 16'h0000);
      checkOutput($sformatf("readback%0d.xa_data_rd", i), 32'(bus.xa_data_rd), 32'(model[i]));
      checkOutput($sformatf("readback%0d.wa_wr_s", i),    32'(bus.wa_wr_s),    32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
